// File: rtl/serial_add_ctrl_if.sv
// Operand/result bus for the bit-serial adder sequencer.
// The master side is the operand source plus result consumer; the slave side
// is the sequencer itself. The subtract request line only exists when
// SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;
  logic             out_ready;

`ifdef SERIAL_ADD_SUB_EN
  modport master (
    output start, a, b, cin, sub, out_ready,
    input  busy, sum, cout, out_valid
  );

  modport slave (
    input  start, a, b, cin, sub, out_ready,
    output busy, sum, cout, out_valid
  );
`else
  modport master (
    output start, a, b, cin, out_ready,
    input  busy, sum, cout, out_valid
  );

  modport slave (
    input  start, a, b, cin, out_ready,
    output busy, sum, cout, out_valid
  );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer.
// One full-adder cell (two half-adder stages plus an OR) is reused for WIDTH
// cycles, consuming operand bits LSB-first and shifting result bits into the
// MSB of the sum register. Start/busy handshake on the operand side,
// valid/ready on the result side.
// Optional feature: define SERIAL_ADD_SUB_EN to add a 'sub' request that
// computes a-b as a + ~b + 1 (cout=1 then means no borrow).
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  serial_add_ctrl_if.slave bus
);

  // Counter must be at least one bit wide even when WIDTH is 1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             ha1Sum, ha1Carry, ha2Sum, ha2Carry, carryNext;
  logic [WIDTH-1:0] bLoad;
  logic             carryLoad;

  // Shared full-adder cell built from two half-adders and an OR.
  always_comb begin
    ha1Sum    = a_sr_q[0] ^ b_sr_q[0];
    ha1Carry  = a_sr_q[0] & b_sr_q[0];
    ha2Sum    = ha1Sum ^ carry_q;
    ha2Carry  = ha1Sum & carry_q;
    carryNext = ha1Carry | ha2Carry;
  end

  // Operand B and initial carry as loaded on accept; subtract inverts B and forces carry-in.
  always_comb begin
    bLoad     = bus.b;
    carryLoad = bus.cin;
`ifdef SERIAL_ADD_SUB_EN
    if (bus.sub) begin
      bLoad     = ~bus.b;
      carryLoad = 1'b1;
    end
`endif
  end

  // Next-state and datapath update; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bLoad;
          carry_d = carryLoad;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = carryNext;
        sum_d   = (sum_q >> 1) | (WIDTH'(ha2Sum) << (WIDTH - 1));
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          cout_d  = carryNext;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status outputs decode straight from the state register.
  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.out_valid = (state_q == DONE);
    bus.sum       = sum_q;
    bus.cout      = cout_q;
  end

endmodule
